debounce_bank: RTL

//  Multi-channel debouncer for push-buttons and switches. Each channel has:
//  - a 2-flop synchroniser;
//  - a stability counter;
//  - a debounced level;
//  - one-cycle rise/fall strobes.

---
 rtl/debounce_bank.sv | 128 ++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// Multi-channel push-button/switch debouncer: per-channel 2-flop synchroniser,
// stability counter, debounced level and rise/fall strobes. Optional hold/auto-repeat
// strobe per channel is built only when `DEBOUNCE_HOLD_EN is defined.
module debounce_bank #(
   parameter int                NUM_CH     = 4,
   parameter int                CLK_FREQ   = 50_000_000,
   parameter int                STABLE_MS  = 20,
   parameter logic [NUM_CH-1:0] ACTIVE_LOW = '0,
   parameter int                HOLD_MS    = 1000,
   parameter int                REPEAT_MS  = 250
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] btn_i,
   output logic [NUM_CH-1:0] level_o,
   output logic [NUM_CH-1:0] rise_o,
   output logic [NUM_CH-1:0] fall_o,
   output logic              any_o,
   output logic [NUM_CH-1:0] hold_o
);

   localparam int TICKS_PER_MS = CLK_FREQ / 1000;
   localparam int MAX_RAW      = TICKS_PER_MS * STABLE_MS;
   localparam int MAX_CNT      = (MAX_RAW < 1) ? 1 : MAX_RAW;
   localparam int CW           = $clog2(MAX_CNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CNT - 1);

`ifdef DEBOUNCE_HOLD_EN
   localparam int HOLD_RAW = TICKS_PER_MS * HOLD_MS;
   localparam int HOLD_CNT = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
   localparam int REP_RAW  = TICKS_PER_MS * REPEAT_MS;
   localparam int REP_CNT  = (REP_RAW < 1) ? 1 : REP_RAW;
   localparam int HW       = $clog2(HOLD_CNT + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CNT);
   // A repeat period longer than the initial hold collapses to the hold period.
   localparam logic [HW-1:0] HOLD_RELOAD =
      (HOLD_CNT > REP_CNT) ? HW'(HOLD_CNT - REP_CNT) : '0;
`endif

   genvar gi;
   for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic          s0_q, s1_q;
      logic          level_q, level_d;
      logic          rise_q, rise_d;
      logic          fall_q, fall_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // The counter only runs while the synchronised input disagrees with the level.
      always_comb begin
         cnt_d   = '0;
         level_d = level_q;
         rise_d  = 1'b0;
         fall_d  = 1'b0;
         if (s1_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
               level_d = s1_q;
               rise_d  = s1_q;
               fall_d  = ~s1_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
         end else begin
            s0_q    <= btn_i[gi] ^ ACTIVE_LOW[gi];
            s1_q    <= s0_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
         end
      end

      assign level_o[gi] = level_q;
      assign rise_o[gi]  = rise_q;
      assign fall_o[gi]  = fall_q;

`ifdef DEBOUNCE_HOLD_EN
      logic [HW-1:0] hc_q, hc_d;
      logic          hold_q, hold_d;

      // A release decided this cycle wins over a hold strobe due in the same cycle.
      always_comb begin
         hc_d   = hc_q;
         hold_d = 1'b0;
         if (!level_q || fall_d) begin
            hc_d = '0;
         end else if (hc_q == HOLD_LAST) begin
            hold_d = 1'b1;
            hc_d   = (REPEAT_MS > 0) ? HOLD_RELOAD : HOLD_SAT;
         end else if (hc_q != HOLD_SAT) begin
            hc_d = hc_q + HW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            hc_q   <= '0;
            hold_q <= 1'b0;
         end else begin
            hc_q   <= hc_d;
            hold_q <= hold_d;
         end
      end

      assign hold_o[gi] = hold_q;
`endif
   end

`ifndef DEBOUNCE_HOLD_EN
   // Hold timing has no effect in this build; the term folds to a constant zero.
   localparam bit HOLD_CFG_SEEN = (HOLD_MS >= 0) || (REPEAT_MS >= 0);
   assign hold_o = {NUM_CH{HOLD_CFG_SEEN & 1'b0}};
`endif

   assign any_o = |(rise_o | fall_o);

endmodule
